// File: rtl/stereo_frame_buffer.sv
// Stereo frame buffer: captures one left and one right camera frame, then serves
// one-cycle-latency reads to the disparity core while holding both frames frozen.
// Optional per-eye pixel checksums are built when FRAME_CHECKSUM_EN is defined.
module stereo_frame_buffer #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned HEIGHT = 7,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cam_pixel,
  input  logic              cam_valid,
  input  logic              cam_sel,
  input  logic              cam_sof,
  input  logic [ADDR_W-1:0] buffer_href,
  input  logic [ADDR_W-1:0] buffer_vref,
  input  logic              image_sel,
  input  logic              lock,
  output logic [7:0]        image_data,
  output logic              buffer_ready,
  output logic              overflow,
  output logic [15:0]       left_sum,
  output logic [15:0]       right_sum
);

  localparam int unsigned Depth = WIDTH * HEIGHT;
  localparam int unsigned AW    = $clog2(Depth);
  localparam int unsigned CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0]     ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0]     RowLast = RW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] WidthA  = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] HeightA = ADDR_W'(HEIGHT);

  typedef enum logic [1:0] {StFill, StReady, StLocked} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q [2];
  logic [CW-1:0]   col_d [2];
  logic [RW-1:0]   row_q [2];
  logic [RW-1:0]   row_d [2];
  logic [1:0]      done_q, done_d;
  logic            overflow_q, overflow_d;

  logic            clr_all;  // leaving LOCKED: restart both eyes
  logic            sof_clr;  // start of frame accepted for eye cam_sel
  logic            wr_en;
  logic [CW-1:0]   wc;
  logic [RW-1:0]   wr;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;
  logic            rd_in_range;

  logic [7:0]      mem_l [Depth];
  logic [7:0]      mem_r [Depth];

  assign clr_all = (state_q == StLocked) && !lock;
  assign sof_clr = (state_q == StFill) && cam_sof;

  // Next-state logic for FILL -> READY -> LOCKED -> FILL
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill:   if (&done_q) state_d = StReady;
      StReady:  if (lock)    state_d = StLocked;
      StLocked: if (!lock)   state_d = StFill;
      default:  state_d = StFill;
    endcase
  end

  // Write-side counters, done flags and overflow detection
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wc         = col_q[cam_sel];
    wr         = row_q[cam_sel];
    if (clr_all) begin
      col_d  = '{default: '0};
      row_d  = '{default: '0};
      done_d = '0;
    end else if (state_q == StFill) begin
      if (sof_clr) begin
        wc              = '0;
        wr              = '0;
        col_d[cam_sel]  = '0;
        row_d[cam_sel]  = '0;
        done_d[cam_sel] = 1'b0;
      end
      if (cam_valid) begin
        if (sof_clr || !done_q[cam_sel]) begin
          wr_en = 1'b1;
          if (wc == ColLast) begin
            // Last pixel of the frame holds the counters in place
            if (wr == RowLast) begin
              done_d[cam_sel] = 1'b1;
            end else begin
              col_d[cam_sel] = '0;
              row_d[cam_sel] = wr + 1'b1;
            end
          end else begin
            col_d[cam_sel] = wc + 1'b1;
          end
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  assign wr_idx = AW'(wr) * AW'(WIDTH) + AW'(wc);

  // State, counters and flags register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFill;
      col_q      <= '{default: '0};
      row_q      <= '{default: '0};
      done_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage writes; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (cam_sel) mem_r[wr_idx] <= cam_pixel;
      else         mem_l[wr_idx] <= cam_pixel;
    end
  end

  assign rd_in_range = (buffer_href < WidthA) && (buffer_vref < HeightA);
  assign rd_idx      = AW'(buffer_vref) * AW'(WIDTH) + AW'(buffer_href);

  // Registered read port; same-cycle write returns the old contents
  always_ff @(posedge clk) begin
    if (reset) begin
      image_data <= 8'd0;
    end else if (!rd_in_range) begin
      image_data <= 8'd0;
    end else if (image_sel) begin
      image_data <= mem_r[rd_idx];
    end else begin
      image_data <= mem_l[rd_idx];
    end
  end

  assign buffer_ready = (state_q != StFill);
  assign overflow     = overflow_q;

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] sum_q [2];
  logic [15:0] sum_d [2];

  // Per-eye checksum of accepted pixels, cleared with that eye's counters
  always_comb begin
    sum_d = sum_q;
    if (clr_all) begin
      sum_d = '{default: '0};
    end else begin
      if (sof_clr) sum_d[cam_sel] = '0;
      if (wr_en)   sum_d[cam_sel] = sum_d[cam_sel] + {8'd0, cam_pixel};
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (reset) sum_q <= '{default: '0};
    else       sum_q <= sum_d;
  end

  assign left_sum  = sum_q[0];
  assign right_sum = sum_q[1];
`else
  assign left_sum  = 16'd0;
  assign right_sum = 16'd0;
`endif

endmodule
